// File: rtl/clock_disp_pkg.sv
// Shared definitions for the MM:SS clock display path.
// Provides glyph codes, default slot geometry, the slot index enum, the
// registered glyph-select payload and a half-open span test helper.
package clock_disp_pkg;

  localparam int unsigned COORD_W = 10;
  localparam int unsigned GLYPH_W = 4;
  localparam int unsigned BCD2_W  = 8;
  localparam int unsigned MMSS_W  = 16;

  localparam logic [GLYPH_W-1:0] GLYPH_COLON = 4'hA;
  localparam logic [GLYPH_W-1:0] GLYPH_BLANK = 4'hF;

  localparam logic [COORD_W-1:0] DEF_X0      = 10'd100;
  localparam logic [COORD_W-1:0] DEF_DIGIT_W = 10'd75;
  localparam logic [COORD_W-1:0] DEF_GAP     = 10'd15;
  localparam logic [COORD_W-1:0] DEF_COLON_W = 10'd8;

  typedef enum logic [2:0] {
    SLOT_D0,
    SLOT_D1,
    SLOT_COLON,
    SLOT_D2,
    SLOT_D3,
    SLOT_NONE
  } slot_e;

  // Payload handed to the renderer each pixel.
  typedef struct packed {
    logic [COORD_W-1:0] posicion;
    logic [GLYPH_W-1:0] digito;
    logic               valid;
  } glyph_sel_t;

  // True when x lies in [org, org+w); widened so org+w cannot wrap.
  function automatic logic in_span(input logic [COORD_W-1:0] x,
                                   input logic [COORD_W-1:0] org,
                                   input logic [COORD_W-1:0] w);
    logic [COORD_W:0] xe;
    logic [COORD_W:0] lo;
    logic [COORD_W:0] hi;
    xe = {1'b0, x};
    lo = {1'b0, org};
    hi = {1'b0, org} + {1'b0, w};
    return (xe >= lo) && (xe < hi);
  endfunction

endpackage

// File: rtl/bcd_mod60_counter.sv
// Two-digit BCD modulo-60 counter (00..59).
// Ports:
//   clk, reset_n   clock and synchronous active-low reset
//   clr_i          force value to 00 (overrides increments)
//   inc_i          advance by 1
//   inc2_i         advance by 2 (takes precedence over inc_i)
//   value_o        registered BCD value {tens, units}
//   next_c_o       value the register will take at the next edge
//   carry_c_o      this cycle's increment wraps past 59
module bcd_mod60_counter
  import clock_disp_pkg::*;
(
  input  logic              clk,
  input  logic              reset_n,
  input  logic              clr_i,
  input  logic              inc_i,
  input  logic              inc2_i,
  output logic [BCD2_W-1:0] value_o,
  output logic [BCD2_W-1:0] next_c_o,
  output logic              carry_c_o
);

  logic [BCD2_W-1:0] value_q;
  logic [BCD2_W-1:0] value_d;
  logic              carry_c;
  logic [1:0]        step;
  logic [4:0]        units_sum;
  logic [3:0]        tens_sum;

  // BCD add of 0/1/2 with decimal adjust on units, then wrap tens at 6.
  always_comb begin
    value_d   = value_q;
    carry_c   = 1'b0;
    step      = inc2_i ? 2'd2 : (inc_i ? 2'd1 : 2'd0);
    units_sum = 5'(value_q[3:0]) + 5'(step);
    tens_sum  = value_q[7:4];
    if (units_sum >= 5'd10) begin
      units_sum = units_sum - 5'd10;
      tens_sum  = tens_sum + 4'd1;
    end
    if (tens_sum >= 4'd6) begin
      tens_sum = 4'd0;
      carry_c  = 1'b1;
    end
    value_d = {tens_sum, units_sum[3:0]};
    if (clr_i) begin
      value_d = '0;
      carry_c = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      value_q <= '0;
    end else begin
      value_q <= value_d;
    end
  end

  assign value_o   = value_q;
  assign next_c_o  = value_d;
  assign carry_c_o = carry_c;

endmodule

// File: rtl/clock_digit_scheduler.sv
// MM:SS digit scheduler for the seven-segment renderer on the VGA path.
// Runs a BCD minutes:seconds count, snapshots it at each frame start, and per
// pixel selects the active glyph slot (D0 D1 : D2 D3) from pixel_x.
// Ports:
//   clk, reset_n          pixel clock, synchronous active-low reset
//   frame_start           pulse at pixel (0,0); latches the display snapshot
//   pixel_x, pixel_y      current pixel position
//   run_en                count seconds while high
//   clear                 zero time and prescaler
//   inc_min               advance minutes by one
//   posicion, digito      registered slot origin and glyph code
//   slot_valid            registered "pixel is inside a slot"
//   pixel_x_d, pixel_y_d  pixel position delayed to line up with the above
//   mm_ss                 live BCD time {m_tens, m_units, s_tens, s_units}
module clock_digit_scheduler
  import clock_disp_pkg::*;
#(
  parameter int unsigned        TICKS_PER_SEC = 25_000_000,
  parameter logic [COORD_W-1:0] X0            = DEF_X0,
  parameter logic [COORD_W-1:0] DIGIT_W       = DEF_DIGIT_W,
  parameter logic [COORD_W-1:0] GAP           = DEF_GAP,
  parameter logic [COORD_W-1:0] COLON_W       = DEF_COLON_W
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               frame_start,
  input  logic [COORD_W-1:0] pixel_x,
  input  logic [COORD_W-1:0] pixel_y,
  input  logic               run_en,
  input  logic               clear,
  input  logic               inc_min,
  output logic [COORD_W-1:0] posicion,
  output logic [GLYPH_W-1:0] digito,
  output logic               slot_valid,
  output logic [COORD_W-1:0] pixel_x_d,
  output logic [COORD_W-1:0] pixel_y_d,
  output logic [MMSS_W-1:0]  mm_ss
);

  localparam int unsigned PRESC_W = (TICKS_PER_SEC > 1) ? $clog2(TICKS_PER_SEC) : 1;

  localparam logic [COORD_W-1:0] ORG_D0    = X0;
  localparam logic [COORD_W-1:0] ORG_D1    = ORG_D0 + DIGIT_W + GAP;
  localparam logic [COORD_W-1:0] ORG_COLON = ORG_D1 + DIGIT_W + GAP;
  localparam logic [COORD_W-1:0] ORG_D2    = ORG_COLON + COLON_W + GAP;
  localparam logic [COORD_W-1:0] ORG_D3    = ORG_D2 + DIGIT_W + GAP;

  logic [PRESC_W-1:0] presc_q;
  logic [PRESC_W-1:0] presc_d;
  logic [MMSS_W-1:0]  disp_q;
  logic [MMSS_W-1:0]  disp_d;
  glyph_sel_t         sel_q;
  glyph_sel_t         sel_d;
  logic [COORD_W-1:0] px_q;
  logic [COORD_W-1:0] py_q;

  logic               sec_tick;
  logic               sec_carry;
  logic               min_carry_unused;
  logic               min_inc1;
  logic               min_inc2;
  logic [BCD2_W-1:0]  sec_q;
  logic [BCD2_W-1:0]  min_q;
  logic [BCD2_W-1:0]  sec_next;
  logic [BCD2_W-1:0]  min_next;
  slot_e              slot;

  // Seconds prescaler: tick on the cycle the count wraps back to 0.
  assign sec_tick = run_en && (presc_q == PRESC_W'(TICKS_PER_SEC - 1));

  always_comb begin
    presc_d = presc_q;
    if (clear) begin
      presc_d = '0;
    end else if (run_en) begin
      presc_d = sec_tick ? '0 : presc_q + PRESC_W'(1);
    end
  end

  // A seconds rollover and an inc_min in the same cycle add two minutes.
  assign min_inc1 = sec_carry ^ inc_min;
  assign min_inc2 = sec_carry & inc_min;

  bcd_mod60_counter u_sec (
    .clk       (clk),
    .reset_n   (reset_n),
    .clr_i     (clear),
    .inc_i     (sec_tick),
    .inc2_i    (1'b0),
    .value_o   (sec_q),
    .next_c_o  (sec_next),
    .carry_c_o (sec_carry)
  );

  bcd_mod60_counter u_min (
    .clk       (clk),
    .reset_n   (reset_n),
    .clr_i     (clear),
    .inc_i     (min_inc1),
    .inc2_i    (min_inc2),
    .value_o   (min_q),
    .next_c_o  (min_next),
    .carry_c_o (min_carry_unused)
  );

  assign mm_ss = {min_q, sec_q};

  // Snapshot takes the post-update time so a coincident clear shows 00:00.
  assign disp_d = frame_start ? {min_next, sec_next} : disp_q;

  // Slot decode on the live pixel column.
  always_comb begin
    slot = SLOT_NONE;
    if (in_span(pixel_x, ORG_D0, DIGIT_W)) begin
      slot = SLOT_D0;
    end else if (in_span(pixel_x, ORG_D1, DIGIT_W)) begin
      slot = SLOT_D1;
    end else if (in_span(pixel_x, ORG_COLON, COLON_W)) begin
      slot = SLOT_COLON;
    end else if (in_span(pixel_x, ORG_D2, DIGIT_W)) begin
      slot = SLOT_D2;
    end else if (in_span(pixel_x, ORG_D3, DIGIT_W)) begin
      slot = SLOT_D3;
    end
  end

  always_comb begin
    sel_d = '{posicion: '0, digito: GLYPH_BLANK, valid: 1'b0};
    case (slot)
      SLOT_D0:    sel_d = '{posicion: ORG_D0,    digito: disp_q[15:12], valid: 1'b1};
      SLOT_D1:    sel_d = '{posicion: ORG_D1,    digito: disp_q[11:8],  valid: 1'b1};
      SLOT_COLON: sel_d = '{posicion: ORG_COLON, digito: GLYPH_COLON,   valid: 1'b1};
      SLOT_D2:    sel_d = '{posicion: ORG_D2,    digito: disp_q[7:4],   valid: 1'b1};
      SLOT_D3:    sel_d = '{posicion: ORG_D3,    digito: disp_q[3:0],   valid: 1'b1};
      default:    sel_d = '{posicion: '0, digito: GLYPH_BLANK, valid: 1'b0};
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      presc_q <= '0;
      disp_q  <= '0;
      sel_q   <= '{posicion: '0, digito: GLYPH_BLANK, valid: 1'b0};
      px_q    <= '0;
      py_q    <= '0;
    end else begin
      presc_q <= presc_d;
      disp_q  <= disp_d;
      sel_q   <= sel_d;
      px_q    <= pixel_x;
      py_q    <= pixel_y;
    end
  end

  assign posicion   = sel_q.posicion;
  assign digito     = sel_q.digito;
  assign slot_valid = sel_q.valid;
  assign pixel_x_d  = px_q;
  assign pixel_y_d  = py_q;

endmodule
